alu_multicycle: RTL
===================

# alu_multicycle

Execute-stage ALU that consumes the 3-bit ALU control code produced by ALU control decode, together with two 32-bit operands, and returns a registered result. AND, OR, ADD and SUB complete in one cycle. MUL runs as a 32-step iterative shift-add, with a busy flag that the hazard/stall logic uses to freeze upstream pipeline registers. Results are presented with a one-cycle valid pulse to the EX/MEM register.

## Interface
- WIDTH, 32, operand/result width; the iteration count of MUL equals WIDTH.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  request; accepted only on an edge where busy_o is 0.
- ALUCtrl_i  input  3  operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL; all other codes are illegal.
- data1_i  input  WIDTH  operand A (rs1).
- data2_i  input  WIDTH  operand B (rs2 or immediate).
- data_o  output  WIDTH  registered result; holds its value until the next completion.
- zero_o  output  1  registered flag, equal to (data_o == 0).
- valid_o  output  1  one-cycle pulse marking a new data_o.
- busy_o  output  1  high while a MUL is in flight; combinational decode of the state.

## Operation
- State machine: IDLE and MUL.
- IDLE, start_i = 1, single-cycle code:
  - Compute the result combinationally and register it into data_o and zero_o.
  - valid_o goes to 1.
  - Stay in IDLE.
- IDLE, start_i = 1, code 011:
  - Load mcand = data1_i and mplier = data2_i; clear acc and cnt.
  - valid_o goes to 0; enter MUL.
- MUL, each edge:
  - If mplier[0] = 1, acc <= acc + mcand (mod 2^WIDTH).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
- MUL, edge with cnt = WIDTH-1:
  - data_o <= final acc; zero_o <= (final acc == 0); valid_o <= 1.
  - Return to IDLE.
- Arithmetic rules:
  - All operations wrap modulo 2^WIDTH; there is no overflow flag.
  - MUL returns the low WIDTH bits of the product, which is correct for both signed and unsigned operands.
  - SUB is data1_i + ~data2_i + 1.
- Illegal code in IDLE with start_i = 1: data_o = 0, zero_o = 1, valid_o = 1, single cycle.
- start_i while busy_o = 1 is ignored. Operands and code are sampled only at acceptance, so their values during MUL are don't-care.
- IDLE with start_i = 0: valid_o goes to 0; data_o and zero_o hold.
- cnt width is clog2(WIDTH) bits.

## Timing
- Reset values: state IDLE, data_o = 0, zero_o = 1, valid_o = 0, busy_o = 0, cnt = 0, acc = 0.
- Reset asserted mid-MUL:
  - Immediate return to reset values; no valid_o pulse.
  - The aborted product is never presented.
- Single-cycle latency: start accepted at edge N gives valid_o = 1 in the cycle after edge N.
- Back-to-back single-cycle starts on consecutive edges give one result per cycle.
- MUL latency:
  - Accepted at edge N; steps run on edges N+1 through N+WIDTH.
  - busy_o = 1 from after edge N until edge N+WIDTH.
  - valid_o = 1 for the cycle after edge N+WIDTH.
- A new start_i may be accepted on edge N+WIDTH+1, which is the same cycle valid_o is high.
- Once valid_o has pulsed, data_o and zero_o stay stable until the next completion.

## Configuration
- ALU_MUL_EN defined:
  - The MUL state, shift-add datapath and counter are built.
  - MUL behaves as described above.
- ALU_MUL_EN undefined:
  - No MUL state, datapath or counter; code 011 is treated as illegal (single cycle, data_o = 0, zero_o = 1).
  - busy_o is tied to 0.

## Test plan
- Reset, then ADD 5 + 7 with start_i for one cycle:
  - data_o = 12, zero_o = 0, valid_o high one cycle after acceptance.
- SUB 3 - 5, then AND 0xF0F0F0F0 & 0x0F0F0F0F on consecutive cycles:
  - data_o = 0xFFFFFFFE, then 0x00000000 with zero_o = 1; valid_o high on both consecutive cycles.
- MUL 0xFFFFFFFF * 3:
  - busy_o high for 32 cycles.
  - data_o = 0xFFFFFFFD with valid_o 32 cycles after acceptance.
  - OR 1 | 2 issued on the next cycle returns 3.
- MUL 1234 * 5678 with start_i = 1 and ADD code held throughout busy:
  - Only one result, 7006652.
  - No extra valid_o pulse until the MUL completes, then one ADD result per cycle after it.
- rst_i pulled low at MUL step 10:
  - Outputs return to reset values immediately; no valid_o pulse.
  - A subsequent ADD 1 + 1 returns 2.
- Illegal code 111 with start_i:
  - data_o = 0, zero_o = 1, valid_o high for one cycle.
  - With ALU_MUL_EN undefined, code 011 gives the same response and busy_o stays 0.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the issue logic and alu_multicycle.
// The master drives the operands and start_i; the slave returns the result and busy_o.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             valid_o;
    logic             busy_o;

    modport master (
        output start_i, ALUCtrl_i, data1_i, data2_i,
        input  data_o, zero_o, valid_o, busy_o
    );

    modport slave (
        input  start_i, ALUCtrl_i, data1_i, data2_i,
        output data_o, zero_o, valid_o, busy_o
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: AND/OR/ADD/SUB in one cycle. When ALU_MUL_EN is defined, MUL is built
// as a WIDTH-step shift-add; without it, code 011 gets the illegal-code response.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    alu_multicycle_if.slave  bus
);
    logic [WIDTH-1:0] alu_res;
    logic             sc_fire;
    logic             mul_done;
    logic [WIDTH-1:0] acc_fin;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    // Illegal codes, and 011 in the no-MUL build, fall through to a zero result.
    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl_i)
            3'b000:  alu_res = bus.data1_i & bus.data2_i;
            3'b001:  alu_res = bus.data1_i | bus.data2_i;
            3'b010:  alu_res = bus.data1_i + bus.data2_i;
            3'b110:  alu_res = bus.data1_i + ~bus.data2_i + WIDTH'(1);
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_e;
    state_e state_q, state_d;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mul_start;

    assign mul_start = (state_q == S_IDLE) && bus.start_i && (bus.ALUCtrl_i == 3'b011);
    assign sc_fire   = (state_q == S_IDLE) && bus.start_i && (bus.ALUCtrl_i != 3'b011);
    assign acc_fin   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_done  = (state_q == S_MUL) && (cnt_q == LAST);
    assign bus.busy_o = (state_q == S_MUL);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_start) state_d = S_MUL;
            S_MUL:   if (cnt_q == LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (mul_start) begin
            mcand_d  = bus.data1_i;
            mplier_d = bus.data2_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == S_MUL) begin
            acc_d    = acc_fin;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign sc_fire    = bus.start_i;
    assign mul_done   = 1'b0;
    assign acc_fin    = '0;
    assign bus.busy_o = 1'b0;
`endif

    always_comb begin
        data_d  = data_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        if (sc_fire) begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            valid_d = 1'b1;
        end else if (mul_done) begin
            data_d  = acc_fin;
            zero_d  = (acc_fin == '0);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q  <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.zero_o  = zero_q;
    assign bus.valid_o = valid_q;
endmodule
